mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and data load/store (EX) requesters.
- Arbitrates with data priority, bounded by a fairness limit so fetch cannot starve.
- Issues one access at a time and tracks the fixed memory latency to return read data and acks to the owning requester.
- Drives a stall to the core while any request is waiting; sits between the core top level and the memory.

Parameters:
- MEM_LAT, 1, cycles from the issue cycle to the cycle mem_rdata is valid; legal range 1..15.
- MAX_DATA_BURST, 2, max consecutive data grants while if_req is pending; legal range 1..7.

Ports:
- clk  in  1  main clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  one-cycle pulse, fetch data valid
- if_rdata  out  32  fetch data, meaningful only while if_rvalid
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  one-cycle pulse: load data valid, or store ack
- d_rdata  out  32  load data, meaningful only while d_rvalid
- mem_en  out  1  memory access strobe, issue cycle only
- mem_we  out  1  memory write enable, issue cycle only
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after issue
- stall  out  1  (if_req & ~if_gnt) | (d_req & ~d_gnt)

Behaviour:
- States: IDLE, BUSY. Owner register: NONE / IF / D. Latency counter lat_cnt (4 b). Fairness counter streak (3 b).
- Grant decision is combinational and allowed only when the port is free. The port is free in IDLE, or in BUSY in the cycle lat_cnt==1 (the return cycle).
- Arbitration:
  - Only one requester: grant it.
  - Both requesting: grant D unless streak==MAX_DATA_BURST; in that case grant IF.
- Issue cycle (any grant):
  - mem_en=1.
  - mem_we = d_we for a D grant, 0 for IF.
  - mem_addr / mem_wdata taken from the granted requester.
  - Next state BUSY; lat_cnt<=MEM_LAT; owner<=granted requester.
- Outside the issue cycle: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- BUSY:
  - lat_cnt decrements each cycle.
  - When lat_cnt==1, pulse the owner's rvalid and drive its rdata = mem_rdata (combinational pass-through). The other requester's rdata is 0.
  - Same cycle: if a grant occurs, stay BUSY with the new owner; otherwise go to IDLE and set owner NONE.
- Throughput: one access per MEM_LAT cycles when requests are back-to-back.
- Stores also produce d_rvalid at issue+MEM_LAT as the ack; d_rdata equals mem_rdata and is don't-care for stores.
- streak:
  - +1 on a D grant while if_req=1 (saturates at MAX_DATA_BURST).
  - Cleared on any IF grant, and in any cycle if_req=0.
- A request dropped before its grant is legal and has no effect. Requests seen while the port is not free receive no grant.
- Reset (reset=0, asynchronous):
  - State IDLE, owner NONE, lat_cnt=0, streak=0.
  - All outputs 0, including stall (combinationally forced).
  - An in-flight access is discarded; no rvalid is ever produced for it.
- Boundary cases:
  - if_req and d_req rising in the same cycle as a return: arbitration is identical to IDLE.
  - streak saturation with if_req=0 does not block D.

Test Plan:
- Reset: hold reset=0 with if_req=d_req=1 -> if_gnt=d_gnt=mem_en=stall=0, no rvalid; release -> d_gnt=1 in the first cycle.
- Lone fetch (MEM_LAT=1): if_req=1, if_addr=0x10 at cycle 0 -> cycle 0: if_gnt=1, mem_en=1, mem_we=0, mem_addr=0x10. Cycle 1: mem_rdata=0xDEADBEEF -> if_rvalid=1, if_rdata=0xDEADBEEF.
- Conflict (MEM_LAT=1): cycle 0 if_req=1 and d_req=1 load 0x200 -> d_gnt at cycle 0, stall=1. Cycle 1: d_rvalid=1, if_gnt=1, mem_addr=if_addr. Cycle 2: if_rvalid=1.
- Fairness (MAX_DATA_BURST=2, MEM_LAT=1): if_req and d_req held high for 6 grants -> grant order D,D,IF,D,D,IF.
- Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x1234 -> cycle 0: mem_we=1, mem_wdata=0x1234. Cycle 1: d_rvalid=1; if_rvalid stays 0.
- Reset mid-op (MEM_LAT=3): IF grant at cycle 0, reset=0 during cycle 1 -> no if_rvalid in cycles 1..5. After release with if_req=1 -> if_gnt in the first cycle, if_rvalid 3 cycles later.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and data (D) requesters.
// Data has priority, bounded by a fairness streak so fetch cannot starve.
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT        = 1,
   parameter int unsigned MAX_DATA_BURST = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        stall
);

   // Handshake: a requester raises *_req with its address/data and holds them
   // until the cycle *_gnt is high; that cycle is the memory issue cycle. The
   // matching *_rvalid pulses exactly MEM_LAT cycles later, with no back-pressure.

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IF,
      OWN_D
   } owner_t;

   typedef struct packed {
      state_t     state;
      owner_t     owner;
      logic [3:0] lat_cnt;
      logic [2:0] streak;
   } arb_t;

   localparam logic [3:0] LAT   = 4'(MEM_LAT);
   localparam logic [2:0] BURST = 3'(MAX_DATA_BURST);

   arb_t arb_q;
   arb_t arb_d;

   logic ret_cycle;
   logic port_free;
   logic grant_if;
   logic grant_d;

   // The port frees up in the return cycle, so back-to-back requests issue
   // in the same cycle the previous access completes.
   always_comb begin
      ret_cycle = (arb_q.state == ST_BUSY) && (arb_q.lat_cnt == 4'd1);
      port_free = (arb_q.state == ST_IDLE) || ret_cycle;
      grant_if  = 1'b0;
      grant_d   = 1'b0;
      if (reset && port_free) begin
         if (d_req && !(if_req && (arb_q.streak == BURST))) begin
            grant_d = 1'b1;
         end else if (if_req) begin
            grant_if = 1'b1;
         end
      end
   end

   always_comb begin
      arb_d = arb_q;
      if (arb_q.state == ST_BUSY) begin
         arb_d.lat_cnt = arb_q.lat_cnt - 4'd1;
      end
      if (ret_cycle) begin
         arb_d.state   = ST_IDLE;
         arb_d.owner   = OWN_NONE;
         arb_d.lat_cnt = 4'd0;
      end
      if (grant_if || grant_d) begin
         arb_d.state   = ST_BUSY;
         arb_d.lat_cnt = LAT;
         arb_d.owner   = grant_d ? OWN_D : OWN_IF;
      end

      // Streak only counts data wins that actually made fetch wait.
      if (!if_req || grant_if) begin
         arb_d.streak = 3'd0;
      end else if (grant_d && (arb_q.streak < BURST)) begin
         arb_d.streak = arb_q.streak + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         arb_q <= '{state: ST_IDLE, owner: OWN_NONE, lat_cnt: 4'd0, streak: 3'd0};
      end else begin
         arb_q <= arb_d;
      end
   end

   always_comb begin
      if_gnt    = grant_if;
      d_gnt     = grant_d;
      if_rvalid = reset && ret_cycle && (arb_q.owner == OWN_IF);
      d_rvalid  = reset && ret_cycle && (arb_q.owner == OWN_D);
      if_rdata  = if_rvalid ? mem_rdata : 32'd0;
      d_rdata   = d_rvalid ? mem_rdata : 32'd0;

      mem_en    = grant_if || grant_d;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      if (grant_d) begin
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (grant_if) begin
         mem_addr  = if_addr;
      end

      stall = reset && ((if_req && !grant_if) || (d_req && !grant_d));
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of per-cycle vectors on a
// MEM_LAT=1 instance, plus hand sequences on a MEM_LAT=3 instance.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] mem_rdata;

   logic        if_gnt_a, if_rvalid_a, d_gnt_a, d_rvalid_a, mem_en_a, mem_we_a, stall_a;
   logic [31:0] if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a;
   logic        if_gnt_b, if_rvalid_b, d_gnt_b, d_rvalid_b, mem_en_b, mem_we_b, stall_b;
   logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b;

   int checks;
   int failures;

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [31:0] dwd;
      logic [31:0] mr;
      logic        e_if_gnt;
      logic        e_if_rv;
      logic [31:0] e_if_rd;
      logic        e_d_gnt;
      logic        e_d_rv;
      logic [31:0] e_d_rd;
      logic        e_men;
      logic        e_mwe;
      logic [31:0] e_ma;
      logic [31:0] e_mwd;
      logic        e_stall;
   } vec_t;

   vec_t vecs[$];

   mem_port_arbiter #(.MEM_LAT(1), .MAX_DATA_BURST(2)) dut_a (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_a),
      .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
      .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata), .stall(stall_a)
   );

   mem_port_arbiter #(.MEM_LAT(3), .MAX_DATA_BURST(2)) dut_b (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_b),
      .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
      .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata), .stall(stall_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mr,
                      input logic eig, input logic eiv, input logic [31:0] eird,
                      input logic edg, input logic edv, input logic [31:0] edrd,
                      input logic men, input logic mwe, input logic [31:0] ma,
                      input logic [31:0] mwd, input logic est);
      vec_t v;
      v = '{ir, ia, dr, dw, da, dwd, mr, eig, eiv, eird, edg, edv, edrd, men, mwe, ma, mwd, est};
      vecs.push_back(v);
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mr);
      if_req    = ir;
      if_addr   = ia;
      d_req     = dr;
      d_we      = dw;
      d_addr    = da;
      d_wdata   = dwd;
      mem_rdata = mr;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_b_quiet(input string tag);
      chk({tag, " b if_gnt"}, 32'(if_gnt_b), 32'd0);
      chk({tag, " b d_gnt"}, 32'(d_gnt_b), 32'd0);
      chk({tag, " b if_rvalid"}, 32'(if_rvalid_b), 32'd0);
      chk({tag, " b d_rvalid"}, 32'(d_rvalid_b), 32'd0);
      chk({tag, " b mem_en"}, 32'(mem_en_b), 32'd0);
      chk({tag, " b stall"}, 32'(stall_b), 32'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      drive(1'b1, 32'h20, 1'b1, 1'b0, 32'h24, 32'h0, 32'h0);

      // lone fetch, then a load colliding with a fetch
      add(0, 32'h0,   0, 0, 32'h0,   32'h0,    32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,   32'h0,    0);
      add(1, 32'h10,  0, 0, 32'h0,   32'h0,    32'h0,        1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h10,  32'h0,    0);
      add(0, 32'h0,   0, 0, 32'h0,   32'h0,    32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,    0);
      add(1, 32'h100, 1, 0, 32'h200, 32'h0,    32'h5555,     0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h200, 32'h0,    1);
      add(1, 32'h100, 0, 0, 32'h0,   32'hBEEF, 32'hA5A5A5A5, 1, 0, 32'h0,        0, 1, 32'hA5A5A5A5, 1, 0, 32'h100, 32'h0,    0);
      add(0, 32'h0,   0, 0, 32'h0,   32'h0,    32'h11112222, 0, 1, 32'h11112222, 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,    0);
      // fairness: D, D, IF, D, D, IF
      add(1, 32'h300, 1, 0, 32'h400, 32'h0,    32'h1,        0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h400, 32'h0,    1);
      add(1, 32'h300, 1, 0, 32'h400, 32'h0,    32'h2,        0, 0, 32'h0,        1, 1, 32'h2,        1, 0, 32'h400, 32'h0,    1);
      add(1, 32'h300, 1, 0, 32'h400, 32'h0,    32'h3,        1, 0, 32'h0,        0, 1, 32'h3,        1, 0, 32'h300, 32'h0,    1);
      add(1, 32'h300, 1, 0, 32'h400, 32'h0,    32'h4,        0, 1, 32'h4,        1, 0, 32'h0,        1, 0, 32'h400, 32'h0,    1);
      add(1, 32'h300, 1, 0, 32'h400, 32'h0,    32'h5,        0, 0, 32'h0,        1, 1, 32'h5,        1, 0, 32'h400, 32'h0,    1);
      add(1, 32'h300, 1, 0, 32'h400, 32'h0,    32'h6,        1, 0, 32'h0,        0, 1, 32'h6,        1, 0, 32'h300, 32'h0,    1);
      add(0, 32'h0,   0, 0, 32'h0,   32'h0,    32'h7,        0, 1, 32'h7,        0, 0, 32'h0,        0, 0, 32'h0,   32'h0,    0);
      // store and its ack
      add(0, 32'h0,   1, 1, 32'h40,  32'h1234, 32'h9,        0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h40,  32'h1234, 0);
      add(0, 32'h0,   0, 0, 32'h0,   32'h0,    32'h77,       0, 0, 32'h0,        0, 1, 32'h77,       0, 0, 32'h0,   32'h0,    0);
      // back-to-back loads, one per cycle
      add(0, 32'h0,   1, 0, 32'h50,  32'h0,    32'h8,        0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h50,  32'h0,    0);
      add(0, 32'h0,   1, 0, 32'h54,  32'h0,    32'h9,        0, 0, 32'h0,        1, 1, 32'h9,        1, 0, 32'h54,  32'h0,    0);
      add(0, 32'h0,   1, 0, 32'h58,  32'h0,    32'hA,        0, 0, 32'h0,        1, 1, 32'hA,        1, 0, 32'h58,  32'h0,    0);
      add(0, 32'h0,   0, 0, 32'h0,   32'h0,    32'hB,        0, 0, 32'h0,        0, 1, 32'hB,        0, 0, 32'h0,   32'h0,    0);
      // saturated streak with if_req low: D still wins and streak clears
      add(1, 32'h300, 1, 0, 32'h400, 32'h0,    32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h400, 32'h0,    1);
      add(1, 32'h300, 1, 0, 32'h400, 32'h0,    32'hC,        0, 0, 32'h0,        1, 1, 32'hC,        1, 0, 32'h400, 32'h0,    1);
      add(0, 32'h0,   1, 0, 32'h404, 32'h0,    32'hD,        0, 0, 32'h0,        1, 1, 32'hD,        1, 0, 32'h404, 32'h0,    0);
      add(1, 32'h300, 1, 0, 32'h408, 32'h0,    32'hE,        0, 0, 32'h0,        1, 1, 32'hE,        1, 0, 32'h408, 32'h0,    1);
      add(0, 32'h0,   0, 0, 32'h0,   32'h0,    32'hF,        0, 0, 32'h0,        0, 1, 32'hF,        0, 0, 32'h0,   32'h0,    0);

      // reset held with both requests high
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst a if_gnt", 32'(if_gnt_a), 32'd0);
      chk("rst a d_gnt", 32'(d_gnt_a), 32'd0);
      chk("rst a mem_en", 32'(mem_en_a), 32'd0);
      chk("rst a stall", 32'(stall_a), 32'd0);
      chk("rst a if_rvalid", 32'(if_rvalid_a), 32'd0);
      chk("rst a d_rvalid", 32'(d_rvalid_a), 32'd0);
      chk_b_quiet("rst");

      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      chk("rel a d_gnt", 32'(d_gnt_a), 32'd1);
      chk("rel a if_gnt", 32'(if_gnt_a), 32'd0);
      chk("rel a mem_addr", mem_addr_a, 32'h24);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

      foreach (vecs[i]) begin
         next_cycle();
         drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dwd, vecs[i].mr);
         @(negedge clk);
         chk($sformatf("v%0d if_gnt", i), 32'(if_gnt_a), 32'(vecs[i].e_if_gnt));
         chk($sformatf("v%0d if_rvalid", i), 32'(if_rvalid_a), 32'(vecs[i].e_if_rv));
         chk($sformatf("v%0d if_rdata", i), if_rdata_a, vecs[i].e_if_rd);
         chk($sformatf("v%0d d_gnt", i), 32'(d_gnt_a), 32'(vecs[i].e_d_gnt));
         chk($sformatf("v%0d d_rvalid", i), 32'(d_rvalid_a), 32'(vecs[i].e_d_rv));
         chk($sformatf("v%0d d_rdata", i), d_rdata_a, vecs[i].e_d_rd);
         chk($sformatf("v%0d mem_en", i), 32'(mem_en_a), 32'(vecs[i].e_men));
         chk($sformatf("v%0d mem_we", i), 32'(mem_we_a), 32'(vecs[i].e_mwe));
         chk($sformatf("v%0d mem_addr", i), mem_addr_a, vecs[i].e_ma);
         chk($sformatf("v%0d mem_wdata", i), mem_wdata_a, vecs[i].e_mwd);
         chk($sformatf("v%0d stall", i), 32'(stall_a), 32'(vecs[i].e_stall));
      end

      // MEM_LAT=3: reset discards an in-flight fetch
      next_cycle();
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      next_cycle();
      reset = 1'b1;
      next_cycle();
      drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("mid c0 b if_gnt", 32'(if_gnt_b), 32'd1);
      chk("mid c0 b mem_addr", mem_addr_b, 32'h80);
      next_cycle();
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1111);
      @(negedge clk);
      chk_b_quiet("mid c1");
      for (int c = 2; c <= 5; c++) begin
         next_cycle();
         reset = 1'b1;
         mem_rdata = 32'h2000 + 32'(c);
         @(negedge clk);
         chk($sformatf("mid c%0d b if_rvalid", c), 32'(if_rvalid_b), 32'd0);
      end

      // fresh fetch after release; a load arriving while busy gets no grant
      next_cycle();
      drive(1'b1, 32'h90, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("c6 b if_gnt", 32'(if_gnt_b), 32'd1);
      chk("c6 b mem_addr", mem_addr_b, 32'h90);
      next_cycle();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 32'h0);
      @(negedge clk);
      chk("c7 b d_gnt", 32'(d_gnt_b), 32'd0);
      chk("c7 b stall", 32'(stall_b), 32'd1);
      chk("c7 b mem_en", 32'(mem_en_b), 32'd0);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("c8 b if_rvalid", 32'(if_rvalid_b), 32'd0);
      chk("c8 b stall", 32'(stall_b), 32'd0);
      // both requests rise in the return cycle: data wins as from idle
      next_cycle();
      drive(1'b1, 32'hA0, 1'b1, 1'b0, 32'h600, 32'h0, 32'h3C3C3C3C);
      @(negedge clk);
      chk("c9 b if_rvalid", 32'(if_rvalid_b), 32'd1);
      chk("c9 b if_rdata", if_rdata_b, 32'h3C3C3C3C);
      chk("c9 b d_rdata", d_rdata_b, 32'h0);
      chk("c9 b d_gnt", 32'(d_gnt_b), 32'd1);
      chk("c9 b if_gnt", 32'(if_gnt_b), 32'd0);
      chk("c9 b mem_addr", mem_addr_b, 32'h600);
      chk("c9 b stall", 32'(stall_b), 32'd1);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("c10 b if_rvalid", 32'(if_rvalid_b), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("c11 b d_rvalid", 32'(d_rvalid_b), 32'd0);
      next_cycle();
      mem_rdata = 32'h600D600D;
      @(negedge clk);
      chk("c12 b d_rvalid", 32'(d_rvalid_b), 32'd1);
      chk("c12 b d_rdata", d_rdata_b, 32'h600D600D);
      chk("c12 b if_rvalid", 32'(if_rvalid_b), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
